// File: rtl/rv32_bridge_pkg.sv
// Shared types and constants for the RV32 native-port to BRAM bridge family.
// No ports: holds the bridge state encoding, the width of the read-latency
// counter and the default word returned on out-of-range reads.
package rv32_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_WAIT,
    RESP,
    ERR,
    TURN
  } state_t;

  // Counter width; wide enough to hold the largest supported read latency (4).
  localparam int LAT_CNT_W = 3;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rv32_range_check.sv
// Combinational address-window decode, shared by the sibling bridges.
// Ports:
//   addr      in   32-bit byte address
//   in_range  out  1 when BaseAddress <= addr <= EndAddress (unsigned)
module rv32_range_check #(
  parameter logic [31:0] BaseAddress = 32'h0000_0000,
  parameter logic [31:0] EndAddress  = 32'h0000_3FFF
) (
  input  logic [31:0] addr,
  output logic        in_range
);

  // Both bounds are tested through a 33-bit difference: bit 32 is the borrow,
  // so there is no wraparound at 32'hFFFF_FFFF and a zero base still
  // produces a real compare rather than a constant one.
  logic [32:0] lo_diff;
  logic [32:0] hi_diff;

  assign lo_diff  = {1'b0, addr} - {1'b0, BaseAddress};
  assign hi_diff  = {1'b0, EndAddress} - {1'b0, addr};
  assign in_range = ~lo_diff[32] & ~hi_diff[32];

endmodule

// File: rtl/rv32_bram_bridge.sv
// Bridge from the RV32 core's valid/ready memory port to a BRAM wrapper with
// byte addressing, a 4-bit write strobe and a fixed read latency.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cpu_valid/addr/wdata/wstrb   core request (wstrb==0 is a read)
//   cpu_ready, cpu_rdata  registered one-cycle completion pulse and read data
//   ram_addr, ram_wr, ram_din    RAM strobes (word-aligned address)
//   ram_dout              RAM read data, valid read_latency cycles after ram_addr
//   bus_err, err_addr     sticky out-of-range flag and first offending address
//   err_clr               clears bus_err and err_addr (wins over a new error)
module rv32_bram_bridge
  import rv32_bridge_pkg::*;
#(
  parameter logic [31:0] BaseAddress    = 32'h0000_0000,
  parameter logic [31:0] EndAddress     = 32'h0000_3FFF,
  parameter int          ram_addr_width = 16,
  parameter int          read_latency   = 1,   // supported range 1..4
  parameter logic [31:0] err_data       = ERR_DATA
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_valid,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  input  logic [3:0]                cpu_wstrb,
  output logic                      cpu_ready,
  output logic [31:0]               cpu_rdata,
  output logic [ram_addr_width-1:0] ram_addr,
  output logic [3:0]                ram_wr,
  output logic [31:0]               ram_din,
  input  logic [31:0]               ram_dout,
  output logic                      bus_err,
  output logic [31:0]               err_addr,
  input  logic                      err_clr
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(read_latency);

  state_t                 state;
  logic [LAT_CNT_W-1:0]   lat_cnt;
  logic                   acc_is_rd;
  logic [31:0]            acc_addr;
  logic                   in_range;
  logic [ram_addr_width-1:0] addr_aligned;

  rv32_range_check #(
    .BaseAddress (BaseAddress),
    .EndAddress  (EndAddress)
  ) u_range (
    .addr     (cpu_addr),
    .in_range (in_range)
  );

  assign addr_aligned = {cpu_addr[ram_addr_width-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      acc_is_rd <= 1'b0;
      acc_addr  <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      ram_addr  <= '0;
      ram_wr    <= '0;
      ram_din   <= '0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      // Strobe and ready are pulses; each state re-asserts them when needed.
      ram_wr    <= '0;
      cpu_ready <= 1'b0;

      case (state)
        // Request accept: latch the access and launch the RAM strobes.
        IDLE: begin
          if (cpu_valid) begin
            acc_addr  <= cpu_addr;
            acc_is_rd <= (cpu_wstrb == 4'h0);
            if (!in_range) begin
              state <= ERR;
            end else begin
              ram_addr <= addr_aligned;
              if (cpu_wstrb != 4'h0) begin
                ram_din <= cpu_wdata;
                ram_wr  <= cpu_wstrb;
                state   <= WR;
              end else begin
                lat_cnt <= LAT_LOAD;
                state   <= RD_WAIT;
              end
            end
          end
        end

        // Write strobe cycle: completion is signalled next cycle.
        WR: begin
          cpu_ready <= 1'b1;
          state     <= RESP;
        end

        // Read wait: ram_addr is untouched here, so it stays stable while
        // the RAM pipeline drains; the count reaches 0 in the cycle that
        // ram_dout is valid.
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            cpu_rdata <= ram_dout;
            cpu_ready <= 1'b1;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        // Out-of-range: respond like a normal access, writes leave rdata alone.
        ERR: begin
          cpu_ready <= 1'b1;
          if (acc_is_rd) cpu_rdata <= err_data;
          state <= RESP;
        end

        // Response cycle (cpu_ready high), then one turnaround cycle.
        RESP: state <= TURN;
        TURN: state <= IDLE;

        default: state <= IDLE;
      endcase

      // Sticky error capture; a clear in the same cycle discards the new error.
      if (err_clr) begin
        bus_err  <= 1'b0;
        err_addr <= '0;
      end else if (state == ERR) begin
        bus_err <= 1'b1;
        if (!bus_err) err_addr <= acc_addr;
      end
    end
  end

endmodule

// File: tb/tb_rv32_bram_bridge.sv
// Self-checking bench for rv32_bram_bridge: one instance with read latency 1
// and one with read latency 3, each backed by a behavioural RAM, checked
// against a word-array reference model of the address window.
module tb_rv32_bram_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cpu_valid, err_clr, sel, ram_init;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;

  logic        r1_ready, r3_ready, r1_berr, r3_berr;
  logic [31:0] r1_rdata, r3_rdata, r1_din, r3_din, r1_dout, r3_dout, r1_eaddr, r3_eaddr;
  logic [15:0] r1_addr, r3_addr;
  logic [3:0]  r1_wr, r3_wr;
  logic        v1, v3;

  assign v1 = cpu_valid & ~sel;
  assign v3 = cpu_valid & sel;

  rv32_bram_bridge #(.read_latency(1)) dut1 (
    .clk(clk), .reset(reset), .cpu_valid(v1), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(r1_ready),
    .cpu_rdata(r1_rdata), .ram_addr(r1_addr), .ram_wr(r1_wr), .ram_din(r1_din),
    .ram_dout(r1_dout), .bus_err(r1_berr), .err_addr(r1_eaddr), .err_clr(err_clr)
  );

  rv32_bram_bridge #(.read_latency(3)) dut3 (
    .clk(clk), .reset(reset), .cpu_valid(v3), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(r3_ready),
    .cpu_rdata(r3_rdata), .ram_addr(r3_addr), .ram_wr(r3_wr), .ram_din(r3_din),
    .ram_dout(r3_dout), .bus_err(r3_berr), .err_addr(r3_eaddr), .err_clr(err_clr)
  );

  // View of the currently selected instance.
  logic        ready, bus_err;
  logic [31:0] rdata, ram_din, err_addr;
  logic [15:0] ram_addr;
  logic [3:0]  ram_wr;
  assign ready    = sel ? r3_ready : r1_ready;
  assign rdata    = sel ? r3_rdata : r1_rdata;
  assign ram_addr = sel ? r3_addr  : r1_addr;
  assign ram_wr   = sel ? r3_wr    : r1_wr;
  assign ram_din  = sel ? r3_din   : r1_din;
  assign bus_err  = sel ? r3_berr  : r1_berr;
  assign err_addr = sel ? r3_eaddr : r1_eaddr;

  function automatic logic [31:0] patt(input int i, input int s);
    return (32'(i) * 32'h9E37_79B1) ^ (s == 0 ? 32'h5A5A_0F0F : 32'hA5A5_F0F0);
  endfunction

  // Behavioural RAMs: latency 1 (registered read) and latency 3.
  logic [31:0] mem1 [0:4095];
  logic [31:0] mem3 [0:4095];
  logic [15:0] a3_d1, a3_d2;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) begin
        mem1[i] <= patt(i, 0);
        mem3[i] <= patt(i, 1);
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (r1_wr[b]) mem1[r1_addr[13:2]][8*b +: 8] <= r1_din[8*b +: 8];
        if (r3_wr[b]) mem3[r3_addr[13:2]][8*b +: 8] <= r3_din[8*b +: 8];
      end
    end
    r1_dout <= mem1[r1_addr[13:2]];
    a3_d1   <= r3_addr;
    a3_d2   <= a3_d1;
    r3_dout <= mem3[a3_d2[13:2]];
  end

  // Reference model state, per instance.
  logic [31:0] exp_mem [2][4096];
  logic [31:0] exp_rdata [2];
  logic [15:0] exp_ra [2];
  logic        exp_err [2];
  logic [31:0] exp_eaddr [2];

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      exp_rdata[s] = 0; exp_ra[s] = 0; exp_err[s] = 0; exp_eaddr[s] = 0;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      exp_err[s] = 0; exp_eaddr[s] = 0;
    end
  endtask

  // One handshake; observations are taken on negative edges, cycle n=1 being
  // the cycle after the request was sampled.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input bit clr_mid, output int lat, output logic [31:0] rd,
                      output int wr_cnt, output int wr_n, output logic [3:0] wr_st,
                      output logic [31:0] wr_din, output logic [15:0] a1,
                      output bit held, output logic after_rdy);
    lat = 0; rd = 0; wr_cnt = 0; wr_n = 0; wr_st = 0; wr_din = 0;
    a1 = 0; held = 1; after_rdy = 0;
    @(negedge clk);
    cpu_valid = 1; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = st;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(negedge clk);
      cpu_valid = 0; cpu_addr = $urandom; cpu_wdata = $urandom;
      cpu_wstrb = 4'($urandom);
      err_clr = clr_mid && (n == 1);
      if (n == 1) a1 = ram_addr;
      else if (ram_addr !== a1) held = 0;
      if (ram_wr != 0) begin
        wr_cnt++; wr_n = n; wr_st = ram_wr; wr_din = ram_din;
      end
      if (ready) begin
        lat = n; rd = rdata;
      end
    end
    err_clr = 0;
    @(negedge clk);
    after_rdy = ready;
    if (ram_wr != 0) wr_cnt++;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input bit clr_mid);
    int s, L, lat, wr_cnt, wr_n;
    bit inr, rd_op, held;
    logic [31:0] rd, wr_din;
    logic [3:0] wr_st;
    logic [15:0] a1;
    logic after_rdy;
    s = sel ? 1 : 0;
    L = sel ? 3 : 1;
    inr = (a <= 32'h0000_3FFF);
    rd_op = (st == 4'h0);
    xfer(a, wd, st, clr_mid, lat, rd, wr_cnt, wr_n, wr_st, wr_din, a1, held, after_rdy);

    chk({tag, " latency"}, 32'(lat), (inr && rd_op) ? 32'(2 + L) : 32'd2);
    chk({tag, " single ready"}, 32'(after_rdy), 32'd0);
    if (inr) exp_ra[s] = {a[15:2], 2'b00};
    chk({tag, " ram_addr"}, 32'(a1), 32'(exp_ra[s]));
    chk({tag, " ram_addr held"}, 32'(held), 32'd1);
    if (inr && !rd_op) begin
      exp_mem[s][a[13:2]] = merge(exp_mem[s][a[13:2]], wd, st);
      chk({tag, " wr pulses"}, 32'(wr_cnt), 32'd1);
      chk({tag, " wr cycle"}, 32'(wr_n), 32'd1);
      chk({tag, " wr strobe"}, 32'(wr_st), 32'(st));
      chk({tag, " wr data"}, wr_din, wd);
    end else begin
      chk({tag, " no wr"}, 32'(wr_cnt), 32'd0);
    end
    if (rd_op) exp_rdata[s] = inr ? exp_mem[s][a[13:2]] : 32'hDEAD_BEEF;
    chk({tag, " rdata"}, rd, exp_rdata[s]);
    if (clr_mid) model_clear();
    else if (!inr && !exp_err[s]) begin
      exp_err[s] = 1; exp_eaddr[s] = a;
    end
    chk({tag, " bus_err"}, 32'(bus_err), 32'(exp_err[s]));
    chk({tag, " err_addr"}, err_addr, exp_eaddr[s]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish within time limit, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, p1, p2, r;
    logic [31:0] d1, d2, a, wd;
    logic [3:0] st;

    reset = 1; cpu_valid = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    err_clr = 0; sel = 0; ram_init = 1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4096; i++) exp_mem[s][i] = patt(i, s);
    model_reset();
    repeat (3) @(negedge clk);
    ram_init = 0;

    chk("reset ready", 32'({r1_ready, r3_ready}), 32'd0);
    chk("reset rdata", r1_rdata | r3_rdata, 32'd0);
    chk("reset ram_addr", 32'(r1_addr | r3_addr), 32'd0);
    chk("reset ram_wr", 32'(r1_wr | r3_wr), 32'd0);
    chk("reset ram_din", r1_din | r3_din, 32'd0);
    chk("reset bus_err", 32'({r1_berr, r3_berr}), 32'd0);
    chk("reset err_addr", r1_eaddr | r3_eaddr, 32'd0);
    reset = 0;
    @(negedge clk);

    // Write then read, byte-lane write then read.
    do_op("wr word", 32'h10, 32'h1234_5678, 4'hF, 0);
    do_op("rd word", 32'h10, 32'h0, 4'h0, 0);
    chk("rd word value", rdata, 32'h1234_5678);
    do_op("wr byte", 32'h10, 32'hAABB_CCDD, 4'b0100, 0);
    do_op("rd byte", 32'h10, 32'h0, 4'h0, 0);
    chk("rd byte value", rdata, 32'h12BB_5678);

    // Out-of-range handling and sticky capture.
    do_op("oor rd", 32'h4000, 32'h0, 4'h0, 0);
    chk("oor rd value", rdata, 32'hDEAD_BEEF);
    chk("oor err_addr", err_addr, 32'h4000);
    do_op("oor wr", 32'h8000, 32'h1111_2222, 4'hF, 0);
    chk("oor keeps first", err_addr, 32'h4000);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    model_clear();
    chk("clr bus_err", 32'(bus_err), 32'd0);
    chk("clr err_addr", err_addr, 32'd0);
    do_op("oor again", 32'h4004, 32'h0, 4'h0, 0);
    do_op("oor with clr", 32'h9000, 32'h0, 4'h0, 1);
    do_op("oor after clr", 32'h5000, 32'h0, 4'h0, 0);

    // Window boundaries and alignment.
    do_op("end addr", 32'h3FFF, 32'h0, 4'h0, 0);
    do_op("all ones", 32'hFFFF_FFFF, 32'h0, 4'h0, 0);
    do_op("unaligned wr", 32'h13, 32'hCAFE_F00D, 4'b0001, 0);
    do_op("unaligned rd", 32'h13, 32'h0, 4'h0, 0);

    // Reset in the cycle after a read is accepted.
    @(negedge clk);
    cpu_valid = 1; cpu_addr = 32'h10; cpu_wstrb = 0;
    @(negedge clk);
    cpu_valid = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
    chk("rst mid ready", 32'(ready), 32'd0);
    chk("rst mid ram_wr", 32'(ram_wr), 32'd0);
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    chk("rst mid no response", 32'(pulses), 32'd0);
    do_op("rd after rst", 32'h10, 32'h0, 4'h0, 0);

    // Latency-3 instance.
    sel = 1;
    do_op("l3 wr", 32'h100, 32'h0BAD_F00D, 4'hF, 0);
    do_op("l3 rd", 32'h100, 32'h0, 4'h0, 0);
    do_op("l3 rd end", 32'h3FFC, 32'h0, 4'h0, 0);
    sel = 0;

    // Back-to-back reads with cpu_valid held high.
    @(negedge clk);
    cpu_valid = 1; cpu_addr = 32'h20; cpu_wstrb = 0;
    pulses = 0; p1 = 0; p2 = 0; d1 = 0; d2 = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (ready) begin
        pulses++;
        if (pulses == 1) begin
          p1 = n; d1 = rdata; cpu_addr = 32'h24;
        end else begin
          p2 = n; d2 = rdata; cpu_valid = 0;
        end
      end
    end
    cpu_valid = 0;
    chk("b2b pulses", 32'(pulses), 32'd2);
    chk("b2b first", 32'(p1), 32'd3);
    chk("b2b spacing", 32'(p2 - p1), 32'd5);
    chk("b2b data0", d1, exp_mem[0][8]);
    chk("b2b data1", d2, exp_mem[0][9]);
    exp_rdata[0] = exp_mem[0][9];
    exp_ra[0] = 16'h24;

    // Randomized traffic on both instances.
    for (int i = 0; i < 60; i++) begin
      sel = (i >= 40);
      r = $urandom_range(0, 9);
      if (r < 7) a = $urandom_range(32'h3FFF, 0);
      else a = $urandom_range(32'hFFFF_FFFF, 32'h4000);
      wd = $urandom;
      st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
      do_op("rand", a, wd, st, $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
